// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller <-> datapath/memory signal bundle for multicycle_ctrl
//
// master : the control FSM (consumes OP/ZERO/MEM_READY, drives strobes and selects)
// slave  : the datapath and memory port side
//   OP[6:0]         opcode field of the instruction register
//   ZERO            ALU zero flag, same-cycle
//   MEM_READY       memory completes the current access this cycle
//   MEM_REQ         memory access request
//   MEM_WRITE       store (meaningful only with MEM_REQ)
//   ADR_SRC         memory address select: 0 = PC, 1 = ALUOut
//   IR_WRITE        load IR and OldPC
//   PC_WRITE        load PC from the result bus
//   REG_WRITE       register-file write enable
//   ALU_SRC_A[1:0]  00 = PC, 01 = OldPC, 10 = rs1
//   ALU_SRC_B[1:0]  00 = rs2, 01 = immediate, 10 = constant 4
//   ALU_OP[1:0]     00 = add, 01 = subtract/compare, 10 = funct-decoded
//   RESULT_SRC[1:0] 00 = ALUOut, 01 = read data, 10 = ALU result
//   IMM_SRC[1:0]    00 = I, 01 = S, 10 = B, 11 = J
//   RETIRE          one-cycle pulse in the final state of each instruction
//   ILLEGAL         sticky unsupported-opcode flag
//   STATE[3:0]      current FSM state, for debug
interface multicycle_ctrl_if;
    logic [6:0] OP;
    logic       ZERO;
    logic       MEM_READY;
    logic       MEM_REQ;
    logic       MEM_WRITE;
    logic       ADR_SRC;
    logic       IR_WRITE;
    logic       PC_WRITE;
    logic       REG_WRITE;
    logic [1:0] ALU_SRC_A;
    logic [1:0] ALU_SRC_B;
    logic [1:0] ALU_OP;
    logic [1:0] RESULT_SRC;
    logic [1:0] IMM_SRC;
    logic       RETIRE;
    logic       ILLEGAL;
    logic [3:0] STATE;

    modport master (
        input  OP, ZERO, MEM_READY,
        output MEM_REQ, MEM_WRITE, ADR_SRC, IR_WRITE, PC_WRITE, REG_WRITE,
               ALU_SRC_A, ALU_SRC_B, ALU_OP, RESULT_SRC, IMM_SRC,
               RETIRE, ILLEGAL, STATE
    );

    modport slave (
        output OP, ZERO, MEM_READY,
        input  MEM_REQ, MEM_WRITE, ADR_SRC, IR_WRITE, PC_WRITE, REG_WRITE,
               ALU_SRC_A, ALU_SRC_B, ALU_OP, RESULT_SRC, IMM_SRC,
               RETIRE, ILLEGAL, STATE
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - control FSM for the multicycle RV32I core
//
// Ports:
//   CLK   in  core clock, rising-edge
//   RST_N in  asynchronous active-low reset
//   bus   master modport of multicycle_ctrl_if (opcode/flags in, strobes/selects out)
//
// Strobes and selects are decoded combinationally from the state register
// (plus MEM_READY / ZERO where a state depends on them). ILLEGAL and the
// state are the only registered outputs.
module multicycle_ctrl (
    input  logic               CLK,
    input  logic               RST_N,
    multicycle_ctrl_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    logic       mem_req, mem_write, ir_write, pc_write, reg_write, retire;
    logic       adr_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH:    if (bus.MEM_READY) state_d = DECODE;
            DECODE: begin
                case (bus.OP)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_ITYPE:          state_d = EXECI;
                    OP_JAL:            state_d = JAL;
                    OP_BEQ:            state_d = BEQ;
                    default:           state_d = TRAP;
                endcase
            end
            MEMADR:   state_d = (bus.OP == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (bus.MEM_READY) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: if (bus.MEM_READY) state_d = FETCH;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            JAL:      state_d = ALUWB;
            BEQ:      state_d = FETCH;
            TRAP:     state_d = TRAP;
            default:  state_d = FETCH;   // codes 12-15 recover to FETCH
        endcase
    end

    assign illegal_d = illegal_q | (state_d == TRAP);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        unique case (state_q)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = bus.MEM_READY;
                pc_write   = bus.MEM_READY;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                retire    = bus.MEM_READY;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = bus.ZERO;
                retire    = 1'b1;
            end
            default: ;
        endcase
    end

    // Write strobes are masked by RST_N itself so nothing fires while reset
    // is held, even though the state register already reads FETCH.
    assign bus.MEM_REQ    = mem_req   & RST_N;
    assign bus.MEM_WRITE  = mem_write & RST_N;
    assign bus.IR_WRITE   = ir_write  & RST_N;
    assign bus.PC_WRITE   = pc_write  & RST_N;
    assign bus.REG_WRITE  = reg_write & RST_N;
    assign bus.RETIRE     = retire    & RST_N;
    assign bus.ADR_SRC    = adr_src;
    assign bus.ALU_SRC_A  = alu_src_a;
    assign bus.ALU_SRC_B  = alu_src_b;
    assign bus.ALU_OP     = alu_op;
    assign bus.RESULT_SRC = result_src;
    assign bus.ILLEGAL    = illegal_q;
    assign bus.STATE      = state_q;

    always_comb begin
        case (bus.OP)
            OP_STORE: bus.IMM_SRC = 2'b01;
            OP_BEQ:   bus.IMM_SRC = 2'b10;
            OP_JAL:   bus.IMM_SRC = 2'b11;
            default:  bus.IMM_SRC = 2'b00;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [21:0] sb_q[$];
    string       tag_q[$];

    // {STATE, MEM_REQ, MEM_WRITE, ADR_SRC, IR_WRITE, PC_WRITE, REG_WRITE, RETIRE,
    //  ALU_SRC_A, ALU_SRC_B, ALU_OP, RESULT_SRC, IMM_SRC, ILLEGAL}
    function automatic logic [21:0] obs_vec();
        return {bus.STATE, bus.MEM_REQ, bus.MEM_WRITE, bus.ADR_SRC, bus.IR_WRITE,
                bus.PC_WRITE, bus.REG_WRITE, bus.RETIRE, bus.ALU_SRC_A, bus.ALU_SRC_B,
                bus.ALU_OP, bus.RESULT_SRC, bus.IMM_SRC, bus.ILLEGAL};
    endfunction

    // Expected output table for a given state and inputs.
    function automatic logic [21:0] exp_vec(input logic [3:0] st, input logic rdy,
                                            input logic z, input logic [6:0] op);
        logic mreq, mw, adr, irw, pcw, rw, ret, ill;
        logic [1:0] a, b, aop, rs, imm;
        {mreq, mw, adr, irw, pcw, rw, ret, ill} = '0;
        {a, b, aop, rs} = '0;
        case (st)
            4'd0:  begin mreq = 1; b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
            4'd1:  begin a = 2'b01; b = 2'b01; end
            4'd2:  begin a = 2'b10; b = 2'b01; end
            4'd3:  begin mreq = 1; adr = 1; end
            4'd4:  begin rs = 2'b01; rw = 1; ret = 1; end
            4'd5:  begin mreq = 1; mw = 1; adr = 1; ret = rdy; end
            4'd6:  begin a = 2'b10; aop = 2'b10; end
            4'd7:  begin rw = 1; ret = 1; end
            4'd8:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            4'd9:  begin a = 2'b01; b = 2'b10; pcw = 1; end
            4'd10: begin a = 2'b10; aop = 2'b01; pcw = z; ret = 1; end
            4'd11: ill = 1;
            default: ;
        endcase
        imm = (op == 7'b0100011) ? 2'b01 :
              (op == 7'b1100011) ? 2'b10 :
              (op == 7'b1101111) ? 2'b11 : 2'b00;
        return {st, mreq, mw, adr, irw, pcw, rw, ret, a, b, aop, rs, imm, ill};
    endfunction

    task automatic check_pop();
        logic [21:0] e, o;
        string t;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty obs=%0d exp=%0d", 0, 1);
            return;
        end
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        o = obs_vec();
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", t, o, e);
        end
    endtask

    // One clock cycle in the named state: called at posedge+1, drives inputs,
    // pushes the expectation, checks on the falling edge, returns at posedge+1.
    task automatic cyc(input logic [3:0] st, input logic rdy, input logic z, input string tag);
        bus.MEM_READY = rdy;
        bus.ZERO      = z;
        sb_q.push_back(exp_vec(st, rdy, z, bus.OP));
        tag_q.push_back(tag);
        @(negedge CLK);
        check_pop();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_in_reset(input string tag);
        logic [7:0] o;
        o = {bus.MEM_REQ, bus.MEM_WRITE, bus.IR_WRITE, bus.PC_WRITE, bus.REG_WRITE,
             bus.RETIRE, bus.ILLEGAL, 1'b0};
        checks++;
        assert (o === 8'h00) else begin
            errors++;
            $error("FAIL %s_strobes obs=%h exp=%h", tag, o, 8'h00);
        end
        checks++;
        assert (bus.STATE === 4'd0) else begin
            errors++;
            $error("FAIL %s_state obs=%0d exp=%0d", tag, bus.STATE, 0);
        end
    endtask

    task automatic release_reset();
        bus.MEM_READY = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.OP        = 7'b0110011;
        bus.ZERO      = 1'b0;
        bus.MEM_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_in_reset("rst0");
        release_reset();

        // R-type: 0,1,6,7
        cyc(0, 1, 0, "r_fetch");
        cyc(1, 1, 0, "r_decode");
        cyc(6, 1, 0, "r_execr");
        cyc(7, 1, 0, "r_aluwb");

        // lw with 2 FETCH waits and 3 MEMREAD waits: 10 cycles
        bus.OP = 7'b0000011;
        cyc(0, 0, 0, "lw_fwait0");
        cyc(0, 0, 0, "lw_fwait1");
        cyc(0, 1, 0, "lw_fetch");
        cyc(1, 1, 0, "lw_decode");
        cyc(2, 1, 0, "lw_memadr");
        cyc(3, 0, 0, "lw_rwait0");
        cyc(3, 0, 0, "lw_rwait1");
        cyc(3, 0, 0, "lw_rwait2");
        cyc(3, 1, 0, "lw_memread");
        cyc(4, 1, 0, "lw_memwb");

        // sw: 0,1,2,5
        bus.OP = 7'b0100011;
        cyc(0, 1, 0, "sw_fetch");
        cyc(1, 1, 0, "sw_decode");
        cyc(2, 1, 0, "sw_memadr");
        cyc(5, 1, 0, "sw_memwrite");

        // beq taken then not taken
        bus.OP = 7'b1100011;
        cyc(0, 1, 1, "beq1_fetch");
        cyc(1, 1, 1, "beq1_decode");
        cyc(10, 1, 1, "beq1_taken");
        cyc(0, 1, 0, "beq0_fetch");
        cyc(1, 1, 0, "beq0_decode");
        cyc(10, 1, 0, "beq0_nottaken");

        // I-type: 0,1,8,7
        bus.OP = 7'b0010011;
        cyc(0, 1, 0, "i_fetch");
        cyc(1, 1, 0, "i_decode");
        cyc(8, 1, 0, "i_execi");
        cyc(7, 1, 0, "i_aluwb");

        // jal: 0,1,9,7
        bus.OP = 7'b1101111;
        cyc(0, 1, 0, "jal_fetch");
        cyc(1, 1, 0, "jal_decode");
        cyc(9, 1, 0, "jal_jal");
        cyc(7, 1, 0, "jal_aluwb");

        // sw with one MEMWRITE wait: request must hold steady
        bus.OP = 7'b0100011;
        cyc(0, 1, 0, "sw2_fetch");
        cyc(1, 1, 0, "sw2_decode");
        cyc(2, 1, 0, "sw2_memadr");
        cyc(5, 0, 0, "sw2_wwait");
        cyc(5, 1, 0, "sw2_memwrite");

        // illegal opcode: trap and stay there, MEM_READY ignored
        bus.OP = 7'b1110011;
        cyc(0, 1, 0, "trap_fetch");
        cyc(1, 1, 0, "trap_decode");
        for (int i = 0; i < 20; i++)
            cyc(11, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "trap_hold");

        // reset pulse mid-TRAP, applied away from the clock edge
        bus.MEM_READY = 1'b1;
        RST_N = 1'b0;
        #1;
        check_in_reset("rst_trap");
        @(posedge CLK);
        #1;
        check_in_reset("rst_trap_hold");
        release_reset();

        bus.OP = 7'b0110011;
        cyc(0, 0, 0, "post_fwait");
        cyc(0, 1, 0, "post_fetch");
        cyc(1, 1, 0, "post_decode");
        cyc(6, 1, 0, "post_execr");
        cyc(7, 1, 0, "post_aluwb");
        cyc(0, 0, 0, "post_refetch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control FSM for the multicycle RV32I core: sequences a shared datapath (one ALU, one unified instruction/data memory port) through fetch, decode, execute, memory and writeback steps. Supports lw, sw, R-type, I-type ALU, beq and jal; other opcodes trap. Drives the datapath mux selects and write strobes, and feeds ALU_OP to the existing ALU decoder. Stalls on a single-signal memory-ready handshake.

## Interface
- No parameters.
- Clock is CLK; reset is RST_N, asynchronous and active-low.
- CLK  in  1  core clock, rising-edge.
- RST_N  in  1  async active-low reset.
- OP  in  7  opcode field of the instruction register.
- ZERO  in  1  ALU zero flag, valid in the same cycle.
- MEM_READY  in  1  memory completes the current access this cycle.
- MEM_REQ  out  1  memory access request.
- MEM_WRITE  out  1  store; valid only with MEM_REQ.
- ADR_SRC  out  1  memory address: 0 = PC, 1 = ALUOut.
- IR_WRITE  out  1  load IR and OldPC.
- PC_WRITE  out  1  load PC from the result bus.
- REG_WRITE  out  1  register-file write enable.
- ALU_SRC_A  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- ALU_SRC_B  out  2  00 = rs2, 01 = immediate, 10 = constant 4.
- ALU_OP  out  2  00 = add, 01 = subtract/compare, 10 = funct-decoded.
- RESULT_SRC  out  2  00 = ALUOut, 01 = read data, 10 = ALU result.
- IMM_SRC  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- RETIRE  out  1  single-cycle pulse in the final state of each instruction.
- ILLEGAL  out  1  sticky; set on an unsupported opcode.
- STATE  out  4  current state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10, TRAP=11. Codes 12–15 are unreachable; if entered, go to FETCH.
- Outputs not listed for a state are 0 / 00.
- IMM_SRC is combinational from OP in every state:
  - 0100011 → 01; 1100011 → 10; 1101111 → 11; all others → 00.
- FETCH:
  - Outputs: MEM_REQ=1, ADR_SRC=0, ALU_SRC_A=00, ALU_SRC_B=10, ALU_OP=00, RESULT_SRC=10.
  - IR_WRITE = PC_WRITE = MEM_READY.
  - Stay while !MEM_READY, else go to DECODE.
- DECODE:
  - Outputs: ALU_SRC_A=01, ALU_SRC_B=01, ALU_OP=00 (branch/jump target into ALUOut).
  - Next state by OP:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1101111 → JAL
    - 1100011 → BEQ
    - any other → TRAP
- MEMADR:
  - Outputs: ALU_SRC_A=10, ALU_SRC_B=01, ALU_OP=00.
  - Go to MEMREAD if OP=0000011, else MEMWRITE.
- MEMREAD:
  - Outputs: MEM_REQ=1, ADR_SRC=1.
  - Wait for MEM_READY, then go to MEMWB.
- MEMWB: RESULT_SRC=01, REG_WRITE=1, RETIRE=1; go to FETCH.
- MEMWRITE:
  - Outputs: MEM_REQ=1, MEM_WRITE=1, ADR_SRC=1.
  - RETIRE = MEM_READY. Wait for MEM_READY, then go to FETCH.
- EXECR: ALU_SRC_A=10, ALU_SRC_B=00, ALU_OP=10; go to ALUWB.
- EXECI: ALU_SRC_A=10, ALU_SRC_B=01, ALU_OP=10; go to ALUWB.
- ALUWB: RESULT_SRC=00, REG_WRITE=1, RETIRE=1; go to FETCH.
- JAL:
  - Outputs: ALU_SRC_A=01, ALU_SRC_B=10, ALU_OP=00, RESULT_SRC=00, PC_WRITE=1.
  - PC takes the target; ALU computes PC+4. Go to ALUWB.
- BEQ:
  - Outputs: ALU_SRC_A=10, ALU_SRC_B=00, ALU_OP=01, RESULT_SRC=00.
  - PC_WRITE = ZERO; RETIRE=1; go to FETCH.
- TRAP: all strobes 0; ILLEGAL set; FETCH is never re-entered. Only reset exits TRAP.

## Timing
- Reset (RST_N low, asynchronous): state=FETCH, ILLEGAL=0.
  - While RST_N is low, MEM_REQ, MEM_WRITE, IR_WRITE, PC_WRITE, REG_WRITE and RETIRE are forced to 0.
  - The first MEM_REQ appears in the first cycle after RST_N deasserts.
- Reset mid-operation: the instruction is abandoned immediately; no write strobe completes after RST_N falls.
- Handshake: MEM_REQ, MEM_WRITE and ADR_SRC stay stable from assertion until the cycle MEM_READY=1 is sampled.
  - MEM_READY is ignored when MEM_REQ=0.
- All strobes are combinational from state, plus MEM_READY/ZERO where stated; the state register updates on the rising edge.
- Cycles per instruction with MEM_READY tied high:
  - lw 5; sw 4; R-type 4; I-type 4; jal 4; beq 3.
  - Each wait cycle adds 1, in FETCH, MEMREAD or MEMWRITE.
- RETIRE pulses exactly once per legal instruction; never in TRAP.

## Test plan
- Reset, then MEM_READY=1, OP=0110011 → STATE 0,1,6,7,0. REG_WRITE=1 only in cycle 4; RETIRE in cycle 4.
- OP=0000011, MEM_READY low for 2 cycles in FETCH and 3 in MEMREAD → 10 cycles total. IR_WRITE/PC_WRITE high only on the READY cycle; RESULT_SRC=01 in MEMWB.
- OP=0100011, MEM_READY=1 → MEM_WRITE=1 with ADR_SRC=1 in state 5 only; REG_WRITE never 1; IMM_SRC=01 throughout.
- OP=1100011 with ZERO=1, then again with ZERO=0 → PC_WRITE=1 in BEQ for the first, 0 for the second. ALU_OP=01; 3 cycles each.
- OP=1101111 → state 9 with PC_WRITE=1, RESULT_SRC=00, then ALUWB with REG_WRITE=1; IMM_SRC=11.
- OP=1110011 → TRAP, ILLEGAL=1 and held for 20 cycles with no MEM_REQ. Pulse RST_N low mid-TRAP → STATE=0, ILLEGAL=0, strobes 0 during reset.
